dac_frame_sequencer: RTL and testbench
======================================

DAC_FRAME_SEQUENCER -- requirements
Module: dac_frame_sequencer

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2, cs_n-low cycles before spi_start (1..15).
REQ-002 SHALL have parameter CS_GAP, default 4, minimum cs_n-high cycles between frames (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles waiting for spi_new_data (16..65535).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-007 SHALL have ports req_cmd in 4, req_addr in 4, req_data in 8: DAC command fields.
REQ-008 SHALL have ports spi_start out 1, spi_data_in out 16: frame to the SPI master.
REQ-009 SHALL have ports spi_busy in 1, spi_new_data in 1, spi_data_out in 16: SPI master status and shifted-in word.
REQ-010 SHALL have ports cs_n out 1 (DAC chip select), rd_valid out 1, rd_data out 16, idle out 1, err_timeout out 1.

Function
REQ-011 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; frame = {req_cmd, req_addr, req_data}, cmd in bits 15:12.
REQ-012 SHALL implement FSM IDLE -> SETUP -> START -> XFER -> GAP -> IDLE.
REQ-013 IDLE: cs_n=1; when a queued frame exists, pop it into spi_data_in, drive cs_n=0, go SETUP on the next edge.
REQ-014 SETUP: hold cs_n=0 for exactly CS_SETUP cycles, then go START.
REQ-015 START: assert spi_start for exactly one cycle when spi_busy=0; while spi_busy=1, stay in START with spi_start=0.
REQ-016 XFER: on spi_new_data=1, register spi_data_out into rd_data, pulse rd_valid for one cycle, drive cs_n=1, go GAP.
REQ-017 XFER: on reaching TIMEOUT cycles without spi_new_data, set err_timeout (sticky), drive cs_n=1, go GAP, with no rd_valid pulse.
REQ-018 GAP: hold cs_n=1 for exactly CS_GAP cycles, then IDLE; a queued frame then starts with no extra idle cycle.
REQ-019 spi_data_in SHALL stay stable from the SETUP entry until GAP exit.
REQ-020 Latency: with the FSM idle and queue empty, a request accepted on edge E gives cs_n=0 after edge E+1 and spi_start=1 in the cycle after edge E+1+CS_SETUP.
REQ-021 idle SHALL be 1 only when the FSM is in IDLE and the queue is empty.
REQ-022 spi_new_data outside XFER SHALL be ignored.
REQ-023 A push and pop on the same edge SHALL keep the occupancy unchanged, with both frames handled correctly.

Reset
REQ-024 On the edge with rst=0: FSM=IDLE, queue flushed, cs_n=1, spi_start=0, spi_data_in=0, rd_valid=0, rd_data=0, err_timeout=0, req_ready=0; idle=1 from the first cycle after release.
REQ-025 Reset mid-frame SHALL force cs_n=1 on that edge, with no partial-frame rd_valid.
REQ-026 err_timeout SHALL clear only by reset.

Configuration
REQ-027 Macro DAC_SEQ_FIFO_EN defined: the request queue is a 4-entry FIFO, with req_ready = not full.
REQ-028 Macro DAC_SEQ_FIFO_EN undefined: the queue is one holding register, with req_ready = register empty; a push into a register being popped on the same edge is not accepted (req_ready=0 that cycle).

Verification
REQ-029 Single write: cmd=3, addr=1, data=0xA5, spi_new_data after 40 cycles with spi_data_out=0x1234 -> spi_data_in=0x31A5, cs_n low 2 cycles before spi_start, rd_data=0x1234, and rd_valid 1 cycle.
REQ-030 Back-to-back: 4 requests with FIFO_EN -> all accepted without stall, 4 frames, cs_n high exactly 4 cycles between frames.
REQ-031 Without FIFO_EN: 2 requests on consecutive cycles -> second has req_ready=0 until the first pops, and 2 frames are emitted in order.
REQ-032 Timeout: never assert spi_new_data, with TIMEOUT=16 -> err_timeout=1 after 16 XFER cycles, cs_n=1, no rd_valid, and the next frame still proceeds.
REQ-033 spi_busy held 1 for 10 cycles in START -> spi_start stays 0, then pulses exactly once after busy falls.
REQ-034 rst=0 during XFER -> cs_n=1 and all outputs at reset values on that edge, and a queued frame is discarded.

Source files
------------

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: queues DAC command frames and sequences cs_n/spi_start around an SPI master.
// Define DAC_SEQ_FIFO_EN for a 4-entry request FIFO; otherwise a single holding register is used.
module dac_frame_sequencer #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_data,
  output logic        spi_start,
  output logic [15:0] spi_data_in,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  input  logic [15:0] spi_data_out,
  output logic        cs_n,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        idle,
  output logic        err_timeout
);
  typedef enum logic [2:0] {IDLE, SETUP, START, XFER, GAP} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cs_n_q, cs_n_d;
  logic [15:0] data_q, data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  logic        en_q;
  logic        push, pop, q_empty, q_full, gap_done, launch;
  logic [15:0] q_head;
  logic [15:0] frame;
  assign frame     = {req_cmd, req_addr, req_data};
  assign req_ready = en_q && !q_full;
  assign push      = req_valid && req_ready;
`ifdef DAC_SEQ_FIFO_EN
  logic [15:0] mem_q [4];
  logic [1:0]  wp_q, rp_q;
  logic [2:0]  occ_q;
  assign q_empty = occ_q == 3'd0;
  assign q_full  = occ_q == 3'd4;
  assign q_head  = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= frame;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop) rp_q <= rp_q + 2'd1;
      occ_q <= occ_q + 3'(push) - 3'(pop);
    end
  end
`else
  logic [15:0] hold_q;
  logic        hv_q;
  assign q_empty = !hv_q;
  assign q_full  = hv_q;
  assign q_head  = hold_q;
  // ready only when empty, so a push never coincides with a pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      hv_q   <= 1'b0;
      hold_q <= '0;
    end else if (push) begin
      hv_q   <= 1'b1;
      hold_q <= frame;
    end else if (pop) begin
      hv_q <= 1'b0;
    end
  end
`endif
  assign gap_done = state_q == GAP && cnt_q == 16'(CS_GAP - 1);
  assign launch   = (state_q == IDLE || gap_done) && !q_empty;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_n_d     = cs_n_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    pop        = 1'b0;
    spi_start  = 1'b0;
    case (state_q)
      SETUP: begin
        state_d = cnt_q == 16'(CS_SETUP - 1) ? START : SETUP;
        cnt_d   = cnt_q + 16'd1;
      end
      START: begin
        spi_start = !spi_busy;
        state_d   = spi_busy ? START : XFER;
        cnt_d     = '0;
      end
      XFER: begin
        cnt_d = cnt_q + 16'd1;
        if (spi_new_data) begin
          rd_data_d  = spi_data_out;
          rd_valid_d = 1'b1;
          cs_n_d     = 1'b1;
          cnt_d      = '0;
          state_d    = GAP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cs_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = gap_done ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    // the last GAP cycle launches directly so cs_n stays high exactly CS_GAP cycles
    if (launch) begin
      pop     = 1'b1;
      data_d  = q_head;
      cs_n_d  = 1'b0;
      cnt_d   = '0;
      state_d = SETUP;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      en_q       <= 1'b1;
    end
  end
  assign spi_data_in = data_q;
  assign cs_n        = cs_n_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_timeout = err_q;
  assign idle        = state_q == IDLE && q_empty;
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: directed checks of framing, handshake, timeout and reset behaviour.
module tb_dac_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst, req_valid, spi_busy, spi_new_data;
  logic [3:0]  req_cmd, req_addr;
  logic [7:0]  req_data;
  logic [15:0] spi_data_out;
  logic        req_ready, spi_start, cs_n, rd_valid, idle, err_timeout;
  logic [15:0] spi_data_in, rd_data;
  logic        t_req_ready, t_spi_start, t_cs_n, t_rd_valid, t_idle, t_err;
  logic [15:0] t_spi_data_in, t_rd_data;
  int          tests = 0, fails = 0;
  logic [15:0] frames [8];
  int          gaps [8];
  int          nf, ng, nrv;
  always #5 clk = ~clk;
  dac_frame_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out), .cs_n(cs_n),
    .rd_valid(rd_valid), .rd_data(rd_data), .idle(idle), .err_timeout(err_timeout)
  );
  dac_frame_sequencer #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .spi_start(t_spi_start), .spi_data_in(t_spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out), .cs_n(t_cs_n),
    .rd_valid(t_rd_valid), .rd_data(t_rd_data), .idle(t_idle), .err_timeout(t_err)
  );
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic set_req(input logic [15:0] f);
    {req_cmd, req_addr, req_data} = f;
    req_valid = 1'b1;
  endtask
  task automatic do_reset;
    rst = 1'b0; req_valid = 1'b0; spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = '0;
    req_cmd = '0; req_addr = '0; req_data = '0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask
  // answers each spi_start with spi_new_data three XFER cycles later; logs frames and cs_n gaps
  task automatic serve(input int nexp);
    int cd, run;
    logic prev;
    nf = 0; ng = 0; nrv = 0; cd = -1; run = 0; prev = cs_n;
    for (int c = 0; c < 600; c++) begin
      if (rd_valid) nrv++;
      if (spi_start && nf < 8) begin frames[nf] = spi_data_in; nf++; cd = 3; end
      if (!cs_n && prev && nf > 0 && ng < 8) begin gaps[ng] = run; ng++; end
      run = cs_n ? run + 1 : 0;
      prev = cs_n;
      if (idle && nf >= nexp && cd < 0) break;
      spi_new_data = (cd == 0);
      spi_data_out = 16'hC000 | 16'(nf);
      if (cd >= 0) cd--;
      tick;
    end
    spi_new_data = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b1; spi_busy = 1'b0; spi_new_data = 1'b1; spi_data_out = 16'hFFFF;
    {req_cmd, req_addr, req_data} = 16'h1234;
    tick; tick;
    tests++;
    if ({cs_n, spi_start, rd_valid, err_timeout, req_ready, idle} !== 6'b100001) begin
      fails++; $display("FAIL reset_ctrl got %b want 100001", {cs_n, spi_start, rd_valid, err_timeout, req_ready, idle});
    end
    tests++;
    if (spi_data_in !== 16'h0 || rd_data !== 16'h0) begin
      fails++; $display("FAIL reset_data got %h/%h want 0000/0000", spi_data_in, rd_data);
    end
    req_valid = 1'b0; spi_new_data = 1'b0; rst = 1'b1;
    tick;
    tests++;
    if (req_ready !== 1'b1 || idle !== 1'b1 || cs_n !== 1'b1) begin
      fails++; $display("FAIL reset_release got rdy=%b idle=%b cs_n=%b want 1 1 1", req_ready, idle, cs_n);
    end
  endtask
  task automatic test_single_write;
    int n;
    do_reset;
    set_req(16'h31A5);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL sw_ready got %b want 1", req_ready); end
    tick;
    req_valid = 1'b0;
    tests++;
    if (cs_n !== 1'b1 || idle !== 1'b0) begin
      fails++; $display("FAIL sw_after_accept got cs_n=%b idle=%b want 1 0", cs_n, idle);
    end
    tick;
    tests++;
    if (cs_n !== 1'b0 || spi_data_in !== 16'h31A5) begin
      fails++; $display("FAIL sw_frame got cs_n=%b data=%h want 0 31a5", cs_n, spi_data_in);
    end
    n = 0;
    while (!spi_start && n < 20) begin n++; tick; end
    tests++;
    if (n != 2 || cs_n !== 1'b0) begin
      fails++; $display("FAIL sw_setup got %0d cycles cs_n=%b want 2 0", n, cs_n);
    end
    tick;
    repeat (39) tick;
    spi_new_data = 1'b1; spi_data_out = 16'h1234;
    tick;
    spi_new_data = 1'b0;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || cs_n !== 1'b1) begin
      fails++; $display("FAIL sw_read got v=%b d=%h cs_n=%b want 1 1234 1", rd_valid, rd_data, cs_n);
    end
    tick;
    tests++;
    if (rd_valid !== 1'b0 || err_timeout !== 1'b0 || spi_data_in !== 16'h31A5) begin
      fails++; $display("FAIL sw_after got v=%b err=%b data=%h want 0 0 31a5", rd_valid, err_timeout, spi_data_in);
    end
    repeat (3) tick;
    tests++;
    if (idle !== 1'b1 || cs_n !== 1'b1) begin
      fails++; $display("FAIL sw_idle got idle=%b cs_n=%b want 1 1", idle, cs_n);
    end
  endtask
  task automatic test_busy;
    int n;
    do_reset;
    spi_busy = 1'b1;
    set_req(16'h2222);
    tick;
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 13; i++) begin tick; if (spi_start) n++; end
    tests++;
    if (n != 0 || cs_n !== 1'b0) begin
      fails++; $display("FAIL busy_hold got starts=%0d cs_n=%b want 0 0", n, cs_n);
    end
    spi_busy = 1'b0;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin if (spi_start) n++; tick; end
    tests++;
    if (n != 1) begin fails++; $display("FAIL busy_release got starts=%0d want 1", n); end
  endtask
`ifdef DAC_SEQ_FIFO_EN
  task automatic test_back_to_back;
    logic [15:0] f [4];
    int stall;
    f = '{16'h1011, 16'h2122, 16'h3233, 16'h4344};
    do_reset;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      set_req(f[i]);
      if (req_ready !== 1'b1) stall++;
      tick;
    end
    req_valid = 1'b0;
    tests++;
    if (stall != 0) begin fails++; $display("FAIL b2b_stall got %0d stalls want 0", stall); end
    serve(4);
    tests++;
    if (nf != 4 || nrv != 4) begin fails++; $display("FAIL b2b_count got frames=%0d rd=%0d want 4 4", nf, nrv); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i < nf && frames[i] !== f[i]) begin
        fails++; $display("FAIL b2b_order[%0d] got %h want %h", i, frames[i], f[i]);
      end
    end
    tests++;
    if (ng != 3 || gaps[0] != 4 || gaps[1] != 4 || gaps[2] != 4) begin
      fails++; $display("FAIL b2b_gap got n=%0d %0d %0d %0d want 3 4 4 4", ng, gaps[0], gaps[1], gaps[2]);
    end
  endtask
`else
  task automatic test_no_fifo;
    do_reset;
    set_req(16'hA0B1);
    tick;
    set_req(16'hC2D3);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL nf_block got %b want 0", req_ready); end
    tick;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL nf_reopen got %b want 1", req_ready); end
    tick;
    req_valid = 1'b0;
    serve(2);
    tests++;
    if (nf != 2 || nrv != 2) begin fails++; $display("FAIL nf_count got frames=%0d rd=%0d want 2 2", nf, nrv); end
    tests++;
    if (frames[0] !== 16'hA0B1 || frames[1] !== 16'hC2D3) begin
      fails++; $display("FAIL nf_order got %h %h want a0b1 c2d3", frames[0], frames[1]);
    end
    tests++;
    if (ng != 1 || gaps[0] != 4) begin fails++; $display("FAIL nf_gap got n=%0d len=%0d want 1 4", ng, gaps[0]); end
  endtask
`endif
  task automatic test_timeout;
    int n;
    do_reset;
    set_req(16'h7123);
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!t_spi_start && n < 20) begin n++; tick; end
    tick;
    repeat (15) tick;
    tests++;
    if (t_err !== 1'b0 || t_cs_n !== 1'b0) begin
      fails++; $display("FAIL to_early got err=%b cs_n=%b want 0 0", t_err, t_cs_n);
    end
    tick;
    tests++;
    if (t_err !== 1'b1 || t_cs_n !== 1'b1 || t_rd_valid !== 1'b0) begin
      fails++; $display("FAIL to_fire got err=%b cs_n=%b v=%b want 1 1 0", t_err, t_cs_n, t_rd_valid);
    end
    set_req(16'h8456);
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!t_spi_start && n < 20) begin n++; tick; end
    tests++;
    if (t_spi_start !== 1'b1 || t_spi_data_in !== 16'h8456 || t_err !== 1'b1) begin
      fails++; $display("FAIL to_next got start=%b data=%h err=%b want 1 8456 1", t_spi_start, t_spi_data_in, t_err);
    end
    tick;
    spi_new_data = 1'b1; spi_data_out = 16'h5A5A;
    tick;
    spi_new_data = 1'b0;
    tests++;
    if (t_rd_valid !== 1'b1 || t_rd_data !== 16'h5A5A || t_err !== 1'b1) begin
      fails++; $display("FAIL to_read got v=%b d=%h err=%b want 1 5a5a 1", t_rd_valid, t_rd_data, t_err);
    end
  endtask
  task automatic test_reset_mid_frame;
    int n;
    do_reset;
    set_req(16'h1111);
    tick;
    set_req(16'h2222);
    n = 0;
    while (!req_ready && n < 10) begin n++; tick; end
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!spi_start && n < 20) begin n++; tick; end
    tick; tick;
    tests++;
    if (cs_n !== 1'b0 || idle !== 1'b0) begin
      fails++; $display("FAIL rm_xfer got cs_n=%b idle=%b want 0 0", cs_n, idle);
    end
    rst = 1'b0; spi_new_data = 1'b1; spi_data_out = 16'hFFFF;
    tick;
    tests++;
    if ({cs_n, spi_start, rd_valid, err_timeout, req_ready, idle} !== 6'b100001 ||
        spi_data_in !== 16'h0 || rd_data !== 16'h0) begin
      fails++; $display("FAIL rm_reset got %b %h %h want 100001 0000 0000",
        {cs_n, spi_start, rd_valid, err_timeout, req_ready, idle}, spi_data_in, rd_data);
    end
    rst = 1'b1; spi_new_data = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin tick; if (!cs_n || rd_valid || spi_start) n++; end
    tests++;
    if (n != 0 || idle !== 1'b1) begin
      fails++; $display("FAIL rm_discard got activity=%0d idle=%b want 0 1", n, idle);
    end
  endtask
  initial begin
    test_reset;
    test_single_write;
    test_busy;
`ifdef DAC_SEQ_FIFO_EN
    test_back_to_back;
`else
    test_no_fifo;
`endif
    test_timeout;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
